// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encodings and helpers for the configurable UART.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  typedef enum logic [1:0] {DB_5, DB_6, DB_7, DB_8} data_bits_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRK_WAIT} rx_state_t;
  function automatic int def_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction
  function automatic logic [7:0] data_mask(input logic [1:0] db);
    return 8'hff >> (2'd3 - db);
  endfunction
  function automatic logic par_en(input logic [1:0] p);
    return p == PAR_EVEN || p == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: oversample tick divider; cfg_div==0 falls back to the default baud.
module uart_tick_gen #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int DIV_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);
  import uart_pkg::*;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(def_div(CLK_FREQ, DEFAULT_BAUD));
  logic [DIV_W-1:0] cnt, div_q, div_sel;
  assign div_sel = cfg_div == '0 ? DEF_DIV : cfg_div;
  assign tick = cnt == div_q - 1'b1;
  // the divisor only changes on a wrap so a tick period is never cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= div_sel;
    end else if (tick) begin
      cnt   <= '0;
      div_q <= div_sel;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_core_cfg.sv
// uart_core_cfg: runtime-configurable UART (5-8 data bits, parity, 1/2 stop bits)
// with 16x oversampled majority-vote RX and parity/framing/break reporting.
module uart_core_cfg #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic             uart_tx,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_start,
  output logic             tx_busy,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_break
);
  import uart_pkg::*;
  localparam logic [4:0] BIT_END  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP2_END = 5'(2 * OVERSAMPLE - 1);
  localparam logic [3:0] S_A = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_B = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] S_C = 4'(OVERSAMPLE / 2 + 1);
  logic tick;
  uart_tick_gen #(.CLK_FREQ(CLK_FREQ), .DEFAULT_BAUD(DEFAULT_BAUD), .DIV_W(DIV_W)) u_tick (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .tick(tick)
  );
  tx_state_t  tx_st;
  logic [4:0] tx_cnt, tx_end;
  logic [2:0] tx_bit, tx_last;
  logic [7:0] tx_sh;
  logic       tx_pen, tx_pbit, tx_stop2;
  assign tx_end = (tx_st == TX_STOP && tx_stop2) ? STOP2_END : BIT_END;
  // a new bit is put on the line at tick 0 of each 16-tick bit period
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st    <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_last  <= '0;
      tx_sh    <= '0;
      tx_pen   <= 1'b0;
      tx_pbit  <= 1'b0;
      tx_stop2 <= 1'b0;
    end else if (tx_st == TX_IDLE) begin
      if (tx_start) begin
        tx_st    <= TX_START;
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_sh    <= tx_data & data_mask(cfg_data_bits);
        tx_last  <= {1'b1, cfg_data_bits};
        tx_pen   <= par_en(cfg_parity);
        tx_pbit  <= ^(tx_data & data_mask(cfg_data_bits)) ^ (cfg_parity == PAR_ODD);
        tx_stop2 <= cfg_stop2;
      end
    end else if (tick) begin
      tx_cnt <= tx_cnt == tx_end ? '0 : tx_cnt + 1'b1;
      if (tx_cnt == '0)
        uart_tx <= tx_st == TX_START ? 1'b0 : tx_st == TX_DATA ? tx_sh[0] : tx_st == TX_PARITY ? tx_pbit : 1'b1;
      if (tx_cnt == '0 && tx_st == TX_DATA)
        tx_sh <= tx_sh >> 1;
      if (tx_cnt == tx_end) begin
        case (tx_st)
          TX_START: tx_st <= TX_DATA;
          TX_DATA: begin
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == tx_last) tx_st <= tx_pen ? TX_PARITY : TX_STOP;
          end
          TX_PARITY: tx_st <= TX_STOP;
          default: begin
            tx_st   <= TX_IDLE;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end
  rx_state_t  rx_st;
  logic       rx_s1, rx_s2, s_a, s_b, maj;
  logic [3:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [1:0] rx_db;
  logic [7:0] rx_sh;
  logic       rx_pen, rx_odd, rx_x, rx_any, rx_perr, brk;
  assign maj = (s_a & s_b) | (s_a & rx_s2) | (s_b & rx_s2);
  assign brk = !maj && !rx_any;
  // data shifts in at the MSB and is right-aligned to the bit count at STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_st         <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_db         <= '0;
      rx_sh         <= '0;
      rx_pen        <= 1'b0;
      rx_odd        <= 1'b0;
      rx_x          <= 1'b0;
      rx_any        <= 1'b0;
      rx_perr       <= 1'b0;
      s_a           <= 1'b0;
      s_b           <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_valid <= 1'b0;
      if (tick) begin
        rx_cnt <= rx_cnt + 1'b1;
        if (rx_cnt == S_A) s_a <= rx_s2;
        if (rx_cnt == S_B) s_b <= rx_s2;
        case (rx_st)
          RX_IDLE: if (!rx_s2) begin
            rx_st   <= RX_START;
            rx_cnt  <= 4'd1;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_x    <= 1'b0;
            rx_any  <= 1'b0;
            rx_perr <= 1'b0;
            rx_db   <= cfg_data_bits;
            rx_pen  <= par_en(cfg_parity);
            rx_odd  <= cfg_parity == PAR_ODD;
          end
          RX_BRK_WAIT: if (rx_s2) rx_st <= RX_IDLE;
          default: if (rx_cnt == S_C) begin
            case (rx_st)
              RX_START: rx_st <= maj ? RX_IDLE : RX_DATA;
              RX_DATA: begin
                rx_sh  <= {maj, rx_sh[7:1]};
                rx_x   <= rx_x ^ maj;
                rx_any <= rx_any | maj;
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == {1'b1, rx_db}) rx_st <= rx_pen ? RX_PARITY : RX_STOP;
              end
              RX_PARITY: begin
                rx_perr <= rx_x ^ maj ^ rx_odd;
                rx_any  <= rx_any | maj;
                rx_st   <= RX_STOP;
              end
              default: begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_sh >> (2'd3 - rx_db);
                rx_parity_err <= rx_perr;
                rx_frame_err  <= !maj;
                rx_break      <= brk;
                rx_st         <= brk ? RX_BRK_WAIT : RX_IDLE;
              end
            endcase
          end
        endcase
      end
    end
  end
endmodule
